// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : seg_scan_pkg                                              |
// | Purpose  : Shared types, default sizes and a digit-extraction helper |
// |            for the seven-segment scan controller.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package seg_scan_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int SEG_W_DEF      = 7;
  localparam int DWELL_DEF      = 20000;
  localparam int BLANK_DEF      = 16;
  localparam int CBITS_DEF      = 15;

  // Upper bounds for the helper's fixed-width arguments. The image is
  // zero-extended into MAX_IMG_W bits and the caller truncates the
  // returned slice to its own SEG_W.
  localparam int MAX_SEG_W  = 16;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_IMG_W  = MAX_SEG_W * MAX_DIGITS;

  // Returns the segment pattern of digit i (bits [i*seg_w +: seg_w]),
  // right-aligned in a MAX_SEG_W-wide word.
  function automatic logic [MAX_SEG_W-1:0] digit_slice(
    input logic [MAX_IMG_W-1:0] image,
    input int unsigned          i,
    input int unsigned          seg_w
  );
    return MAX_SEG_W'(image >> (i * seg_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_timer                                            |
// | Purpose  : Loadable up-counter that measures one BLANK or DRIVE      |
// |            phase and flags its final cycle.                          |
// | Revision : 1.0  initial release                                      |
// | Ports    : clk, rst   clock, async active-high reset                 |
// |            i_load     restart count at 0 on the next edge            |
// |            i_len      phase length in cycles (>=1)                   |
// |            o_cnt      current position 0..i_len-1                    |
// |            o_done     high in the last cycle of the phase            |
// +----------------------------------------------------------------------+
module seg_scan_timer #(
  parameter int CBITS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CBITS-1:0] i_len,
  output logic [CBITS-1:0] o_cnt,
  output logic             o_done
);

  logic [CBITS-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CBITS'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == (i_len - CBITS'(1)));

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                             |
// | Purpose  : Scan scheduler for a time-multiplexed common-segment      |
// |            seven-segment display. Each digit slot is a blanking gap  |
// |            followed by a drive window. New images arrive over a      |
// |            valid/ready handshake and are double-buffered so they are |
// |            only applied at frame boundaries.                         |
// | Revision : 1.0  initial release                                      |
// | Ports    : clk, rst     clock, async active-high reset               |
// |            load_valid   producer offers an image                     |
// |            load_data    image, digit i at [i*SEG_W +: SEG_W]         |
// |            load_ready   pending buffer empty                         |
// |            segment      segment bus, active-high                     |
// |            digit_en     one-hot digit enable, active-high            |
// |            frame_tick   one-cycle pulse on first cycle of a frame    |
// |            bright       (SEG_SCAN_BRIGHT_EN only) 4-bit brightness   |
// | Macro    : SEG_SCAN_BRIGHT_EN adds the bright input and shortens the |
// |            on-time inside each drive window.                         |
// | Limits   : SEG_W <= 16, NUM_DIGITS <= 8.                              |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SEG_W      = SEG_W_DEF,
  parameter int DWELL      = DWELL_DEF,
  parameter int BLANK      = BLANK_DEF,
  parameter int CBITS      = CBITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [NUM_DIGITS*SEG_W-1:0] load_data,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [3:0]                  bright,
`endif
  output logic                        load_ready,
  output logic [SEG_W-1:0]            segment,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int IMG_W = NUM_DIGITS * SEG_W;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_next_idx;
  logic              w_boundary;

  logic [CBITS-1:0]  w_len;
  logic [CBITS-1:0]  w_cnt;
  logic [CBITS-1:0]  w_next_cnt;
  logic              w_done;
  logic              w_on;

  logic [IMG_W-1:0]  r_active;
  logic [IMG_W-1:0]  r_pending;
  logic              r_load_ready;

  logic [SEG_W-1:0]      r_segment;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_tick;
  logic [SEG_W-1:0]      w_next_seg;

  // ------------------------------------------------------------------
  // Phase timer, restarted on every state change
  // ------------------------------------------------------------------
  assign w_len = (r_state == ST_BLANK) ? CBITS'(BLANK) : CBITS'(DWELL);

  seg_scan_timer #(
    .CBITS (CBITS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_done),
    .i_len  (w_len),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );

  // Counter value the timer will hold after this edge.
  assign w_next_cnt = w_done ? '0 : (w_cnt + CBITS'(1));

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_boundary   = 1'b0;
    if (w_done) begin
      case (r_state)
        ST_BLANK: begin
          w_next_state = ST_DRIVE;
        end
        ST_DRIVE: begin
          w_next_state = ST_BLANK;
          if (r_idx == C_LAST_IDX) begin
            w_next_idx = '0;
            w_boundary = 1'b1;
          end else begin
            w_next_idx = r_idx + IDX_W'(1);
          end
        end
        default: begin
          w_next_state = ST_BLANK;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // On-time inside the drive window
  // ------------------------------------------------------------------
`ifdef SEG_SCAN_BRIGHT_EN
  localparam int OW = CBITS + 4;

  logic [OW-1:0] w_on_raw;
  logic [OW-1:0] w_on_new;
  logic [OW-1:0] w_on_eff;
  logic [OW-1:0] r_on_len;
  logic          w_entering;

  assign w_on_raw   = (OW'(DWELL) * (OW'(bright) + OW'(1))) >> 4;
  assign w_on_new   = (w_on_raw == '0) ? OW'(1) : w_on_raw;
  assign w_entering = w_done && (r_state == ST_BLANK);
  // The window being entered uses the freshly sampled value; an
  // in-progress window keeps the one latched at its start.
  assign w_on_eff   = w_entering ? w_on_new : r_on_len;
  assign w_on       = (OW'(w_next_cnt) < w_on_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_on_len <= OW'(1);
    end else if (w_entering) begin
      r_on_len <= w_on_new;
    end
  end
`else
  // Full window: every drive cycle is on.
  assign w_on = (w_next_cnt < CBITS'(DWELL));
`endif

  // ------------------------------------------------------------------
  // Image double buffer. The boundary copy takes precedence; an accept
  // cannot coincide with it because load_ready is low whenever a copy
  // is due, so an image accepted on a boundary edge waits a full frame.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_load_ready <= 1'b1;
    end else if (w_boundary && !r_load_ready) begin
      r_active     <= r_pending;
      r_load_ready <= 1'b1;
    end else if (load_valid && r_load_ready) begin
      r_pending    <= load_data;
      r_load_ready <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs, computed from next-cycle state so they line up
  // with the state they describe.
  // ------------------------------------------------------------------
  assign w_next_seg = SEG_W'(digit_slice(MAX_IMG_W'(r_active), 32'(w_next_idx), SEG_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segment    <= '0;
      r_digit_en   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if ((w_next_state == ST_DRIVE) && w_on) begin
        r_digit_en <= NUM_DIGITS'(1) << w_next_idx;
        r_segment  <= w_next_seg;
      end else begin
        r_digit_en <= '0;
        r_segment  <= '0;
      end
    end
  end

  assign load_ready = r_load_ready;
  assign segment    = r_segment;
  assign digit_en   = r_digit_en;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                          |
// | Purpose  : Self-checking bench for seg_scan_ctrl (2 digits, 7 segs,  |
// |            DWELL=5, BLANK=2, 14-cycle frame). Directed load cases,   |
// |            randomized producer traffic and an async mid-frame reset, |
// |            all compared against a frame-position reference model.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int ND    = 2;
  localparam int SW    = 7;
  localparam int DW    = 5;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic              clk;
  logic              rst;
  logic              load_valid;
  logic [ND*SW-1:0]  load_data;
  logic              load_ready;
  logic [SW-1:0]     segment;
  logic [ND-1:0]     digit_en;
  logic              frame_tick;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [3:0]        bright;
  initial bright = 4'd15;
`endif

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SEG_W      (SW),
    .DWELL      (DW),
    .BLANK      (BL),
    .CBITS      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
`ifdef SEG_SCAN_BRIGHT_EN
    .bright     (bright),
`endif
    .load_ready (load_ready),
    .segment    (segment),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errs;

  // Reference model: cycle index since reset release plus buffer contents.
  int               t;
  logic [ND*SW-1:0] m_active;
  logic [ND*SW-1:0] m_pend;
  logic             m_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [ND-1:0] exp_en(input int tc);
    int p;
    p = tc % FRAME;
    if ((p % SLOT) < BL) return '0;
    return ND'(1 << (p / SLOT));
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int tc);
    int p;
    logic [ND*SW-1:0] a;
    p = tc % FRAME;
    a = m_active;
    if ((p % SLOT) < BL) return '0;
    return a[(p / SLOT) * SW +: SW];
  endfunction

  function automatic logic exp_tick(input int tc);
    return (tc > 0) && ((tc % FRAME) == 0);
  endfunction

  // Called at a falling edge: check this cycle, drive inputs, advance.
  task automatic do_cycle(input logic v, input logic [ND*SW-1:0] d, output logic acc);
    int p;
    p = t % FRAME;
    check("digit_en",   32'(digit_en),   32'(exp_en(t)));
    check("segment",    32'(segment),    32'(exp_seg(t)));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick(t)));
    check("load_ready", 32'(load_ready), 32'(!m_full));
    load_valid = v;
    load_data  = d;
    @(posedge clk);
    acc = 1'b0;
    if ((p == FRAME - 1) && m_full) begin
      m_active = m_pend;
      m_full   = 1'b0;
    end else if (v && !m_full) begin
      m_pend = d;
      m_full = 1'b1;
      acc    = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    t        = 0;
    m_active = '0;
    m_pend   = '0;
    m_full   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic             v;
    logic [ND*SW-1:0] d;
    logic             acc;
    logic             sec_done;
    logic             busy;
    logic [ND*SW-1:0] pdata;
    int               iter;

    n_checks   = 0;
    n_errs     = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed: first image, a held second image, a boundary-edge accept.
    sec_done = 1'b0;
    while (t < 62) begin
      if (t == 4)  check("ready_drop",    32'(load_ready), 32'h0);
      if (t == 14) check("ready_return",  32'(load_ready), 32'h1);
      if (t == 15) check("second_taken",  32'(load_ready), 32'h0);
      if (t == 18) check("img1_digit0",   32'(segment),    32'h55);
      if (t == 25) check("img1_digit1",   32'(segment),    32'h34);
      if (t == 32) check("img2_digit0",   32'(segment),    32'h3B);
      if (t == 39) check("img2_digit1",   32'(segment),    32'h17);
      if (t == 42) check("edge_accept",   32'(load_ready), 32'h0);
      if (t == 46) check("edge_not_yet",  32'(segment),    32'h3B);
      if (t == 60) check("edge_applied",  32'(segment),    32'h3A);
      if (t == 3) begin
        v = 1'b1; d = 14'h1A55;
      end else if (t >= 5 && !sec_done) begin
        v = 1'b1; d = 14'h0BBB;
      end else if (t == 41) begin
        v = 1'b1; d = 14'h2C3A;
      end else begin
        v = 1'b0; d = '0;
      end
      do_cycle(v, d, acc);
      if (acc && d == 14'h0BBB) sec_done = 1'b1;
    end

    // Randomized producer that holds its offer until it is accepted.
    busy  = 1'b0;
    pdata = '0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && $urandom_range(0, 3) == 0) begin
        busy  = 1'b1;
        pdata = ND*SW'($urandom);
      end
      do_cycle(busy, pdata, acc);
      if (acc) busy = 1'b0;
    end

    // Get a pending image and reach the drive window of digit 1.
    iter = 0;
    while (iter < 200 && !(m_full && (t % FRAME) >= FRAME - DW + 1)) begin
      if (!busy) begin
        busy  = 1'b1;
        pdata = ND*SW'($urandom);
      end
      do_cycle(busy, pdata, acc);
      if (acc) busy = 1'b0;
      iter++;
    end
    check("rst_setup", 32'(iter < 200), 32'h1);
    check("pre_rst_en",    32'(digit_en),   32'(exp_en(t)));
    check("pre_rst_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_digit_en",   32'(digit_en),   32'h0);
    check("arst_segment",    32'(segment),    32'h0);
    check("arst_frame_tick", 32'(frame_tick), 32'h0);
    check("arst_ready",      32'(load_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Restart timing matches reset release; pending image was discarded.
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b0, '0, acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
